// File: rtl/laser_pack_pkg.sv
// Shared types, word tags and word-assembly helpers for the laser multi-channel packer.
// Define LASER_PACK_CKSUM_EN to switch the trailer to the {word_cnt, cksum} form.
package laser_pack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_DATA = 2'd2,
        ST_TAIL = 2'd3
    } state_t;

    localparam logic [15:0] HDR_TAG  = 16'hA5A5;
    localparam logic [15:0] TRL_TAG  = 16'h5A5A;
    localparam logic [11:0] DATA_TAG = 12'h5A6;

    function automatic logic [31:0] mk_data(input logic acc, input logic [2:0] ch, input logic [15:0] s);
        return {acc, ch, DATA_TAG, s};
    endfunction

    function automatic logic [31:0] mk_hdr(input logic [15:0] fc);
        return {HDR_TAG, fc};
    endfunction

`ifdef LASER_PACK_CKSUM_EN
    function automatic logic [31:0] mk_trl(input logic [15:0] wc, input logic [15:0] ck);
        return {wc, ck};
    endfunction
`else
    function automatic logic [31:0] mk_trl(input logic [15:0] wc);
        return {TRL_TAG, wc};
    endfunction
`endif

    function automatic logic [2:0] first_ch(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (m[i]) r = 3'(i);
        return r;
    endfunction

    // Next enabled channel above p, wrapping to the lowest enabled one.
    function automatic logic [2:0] next_ch(input logic [7:0] m, input logic [2:0] p);
        logic [2:0] r;
        r = first_ch(m);
        for (int i = 7; i >= 0; i--)
            if (m[i] && (3'(i) > p)) r = 3'(i);
        return r;
    endfunction

endpackage

// File: rtl/laser_pack_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count and synchronous clear.
module laser_pack_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_vld,
    output logic [AW:0]      o_cnt
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [AW:0]      r_cnt;
    logic             w_full, w_empty, w_wr, w_rd;

    assign w_full  = (r_cnt == (AW+1)'(DEPTH));
    assign w_empty = (r_cnt == '0);
    assign w_wr    = i_wr_en & ~w_full & ~i_clr;
    assign w_rd    = i_rd_en & ~w_empty & ~i_clr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

    // Head word is forced to zero while empty so the output is clean after reset.
    assign o_rd_data = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_vld     = ~w_empty;
    assign o_cnt     = r_cnt;

endmodule

// File: rtl/laser_multi_ch_packer.sv
// Mask-aware round-robin packer: laser samples -> header/data/trailer words in a FWFT buffer.
// Define LASER_PACK_CKSUM_EN to append an XOR checksum of the data words to the trailer.
module laser_multi_ch_packer
    import laser_pack_pkg::*;
#(
    parameter int CH_NUM     = 3,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 1024,
    parameter int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     laser_start_i,
    input  logic                     laser_vld_i,
    input  logic                     laser_acc_flag_i,
    input  logic [CH_NUM*DATA_W-1:0] laser_data_i,
    input  logic [CH_NUM-1:0]        ch_mask_i,
    input  logic                     clear_i,
    input  logic                     tx_rdy_i,
    output logic                     tx_vld_o,
    output logic [31:0]              tx_data_o,
    output logic [FIFO_AW:0]         fifo_cnt_o,
    output logic                     frame_busy_o,
    output logic                     ovf_o,
    output logic [15:0]              ovf_cnt_o
);

    state_t              r_state, w_state_nxt;
    logic                r_start_d, r_rise_pend, r_fall_pend;
    logic [CH_NUM-1:0]   r_mask, w_mask_new;
    logic [2:0]          r_ptr, w_ptr_first, w_ptr_next;
    logic [15:0]         r_frame_cnt, r_word_cnt, r_ovf_cnt, w_sample;
    logic                r_ovf, r_wr_en, w_wr_en;
    logic [31:0]         r_wr_data, w_wr_data;
    logic [FIFO_AW:0]    w_fifo_cnt;
    logic [FIFO_AW+1:0]  w_occ;
    logic                w_rise, w_fall, w_go, w_end, w_room;
`ifdef LASER_PACK_CKSUM_EN
    logic [15:0]         r_cksum;
`endif

    assign w_rise      = laser_start_i & ~r_start_d;
    assign w_fall      = ~laser_start_i & r_start_d;
    assign w_go        = (r_state == ST_IDLE) & (w_rise | r_rise_pend);
    assign w_end       = (r_state == ST_DATA) & (w_fall | r_fall_pend);
    assign w_mask_new  = (ch_mask_i == '0) ? CH_NUM'(1) : ch_mask_i;
    assign w_ptr_first = first_ch(8'(w_mask_new));
    assign w_ptr_next  = next_ch(8'(r_mask), r_ptr);

    // The word already sitting in the write register counts against the reserve.
    assign w_occ  = {1'b0, w_fifo_cnt} + {{(FIFO_AW+1){1'b0}}, r_wr_en};
    assign w_room = (w_occ < (FIFO_AW+2)'(FIFO_DEPTH - 2));

    always_comb begin
        w_sample = '0;
        for (int i = 0; i < CH_NUM; i++)
            if (r_ptr == 3'(i)) w_sample = 16'(laser_data_i[i*DATA_W +: DATA_W]);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_go)  w_state_nxt = ST_HEAD;
            ST_HEAD:            w_state_nxt = ST_DATA;
            ST_DATA: if (w_end) w_state_nxt = ST_TAIL;
            ST_TAIL:            w_state_nxt = ST_IDLE;
            default:            w_state_nxt = ST_IDLE;
        endcase
        if (clear_i) w_state_nxt = ST_IDLE;
    end

    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_data = mk_data(laser_acc_flag_i, r_ptr, w_sample);
        case (r_state)
            ST_HEAD: begin
                w_wr_en   = 1'b1;
                w_wr_data = mk_hdr(r_frame_cnt);
            end
            ST_DATA: w_wr_en = laser_vld_i & w_room;
            ST_TAIL: begin
                w_wr_en   = 1'b1;
`ifdef LASER_PACK_CKSUM_EN
                w_wr_data = mk_trl(r_word_cnt, r_cksum);
`else
                w_wr_data = mk_trl(r_word_cnt);
`endif
            end
            default: w_wr_en = 1'b0;
        endcase
        if (clear_i) w_wr_en = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_start_d   <= 1'b0;
            r_rise_pend <= 1'b0;
            r_fall_pend <= 1'b0;
            r_mask      <= '0;
            r_ptr       <= '0;
            r_frame_cnt <= '0;
            r_word_cnt  <= '0;
            r_ovf       <= 1'b0;
            r_ovf_cnt   <= '0;
            r_wr_en     <= 1'b0;
`ifdef LASER_PACK_CKSUM_EN
            r_cksum     <= '0;
`endif
        end else begin
            r_start_d   <= laser_start_i;
            r_wr_en     <= w_wr_en;
            // A fall arriving while the header goes out is remembered for DATA.
            r_fall_pend <= (r_state == ST_HEAD) & w_fall & ~clear_i;
            if (clear_i || r_state == ST_IDLE) r_rise_pend <= 1'b0;
            else if (w_rise)                   r_rise_pend <= 1'b1;

            if (clear_i) begin
                r_ptr <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: if (w_go) begin
                        r_mask     <= w_mask_new;
                        r_ptr      <= w_ptr_first;
                        r_word_cnt <= '0;
                        r_ovf      <= 1'b0;
                        r_ovf_cnt  <= '0;
`ifdef LASER_PACK_CKSUM_EN
                        r_cksum    <= '0;
`endif
                    end
                    ST_HEAD: r_frame_cnt <= r_frame_cnt + 16'd1;
                    ST_DATA: if (laser_vld_i) begin
                        r_ptr <= w_ptr_next;
                        if (w_room) begin
                            r_word_cnt <= r_word_cnt + 16'd1;
`ifdef LASER_PACK_CKSUM_EN
                            r_cksum    <= r_cksum ^ w_sample;
`endif
                        end else begin
                            r_ovf <= 1'b1;
                            if (r_ovf_cnt != 16'hFFFF) r_ovf_cnt <= r_ovf_cnt + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        r_wr_data <= w_wr_data;
    end

    laser_pack_sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .i_clk     (clk_i),
        .i_rst_n   (rst_n_i),
        .i_clr     (clear_i),
        .i_wr_en   (r_wr_en),
        .i_wr_data (r_wr_data),
        .i_rd_en   (tx_rdy_i),
        .o_rd_data (tx_data_o),
        .o_vld     (tx_vld_o),
        .o_cnt     (w_fifo_cnt)
    );

    assign fifo_cnt_o   = w_fifo_cnt;
    assign frame_busy_o = (r_state != ST_IDLE);
    assign ovf_o        = r_ovf;
    assign ovf_cnt_o    = r_ovf_cnt;

endmodule

// File: tb/tb_laser_multi_ch_packer.sv
// Scoreboard bench for laser_multi_ch_packer (CH_NUM=3, DATA_W=16, FIFO_DEPTH=16).
module tb_laser_multi_ch_packer;

    localparam int CH = 3;
    localparam int DW = 16;
    localparam int D  = 16;
    localparam int AW = $clog2(D);

    logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0, vld = 1'b0, acc = 1'b0;
    logic              clr = 1'b0, rdy = 1'b0;
    logic [CH*DW-1:0]  data = '0;
    logic [CH-1:0]     mask = '0;
    logic              tx_vld, busy, ovf;
    logic [31:0]       tx_data;
    logic [AW:0]       cnt;
    logic [15:0]       ovf_cnt;

    int                n_chk = 0, n_fail = 0;
    logic [31:0]       exp_q[$];
    logic [15:0]       m_fcnt = 16'd0;

    always #5 clk = ~clk;

    laser_multi_ch_packer #(.CH_NUM(CH), .DATA_W(DW), .FIFO_DEPTH(D)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .laser_start_i(start), .laser_vld_i(vld),
        .laser_acc_flag_i(acc), .laser_data_i(data), .ch_mask_i(mask), .clear_i(clr),
        .tx_rdy_i(rdy), .tx_vld_o(tx_vld), .tx_data_o(tx_data), .fifo_cnt_o(cnt),
        .frame_busy_o(busy), .ovf_o(ovf), .ovf_cnt_o(ovf_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mdata(input logic a, input int ch, input logic [15:0] s);
        logic [2:0] c;
        c = 3'(ch);
        return {a, c, 12'h5A6, s};
    endfunction

    function automatic logic [31:0] mtrl(input logic [15:0] wc, input logic [15:0] ck);
`ifdef LASER_PACK_CKSUM_EN
        return {wc, ck};
`else
        return {16'h5A5A, wc} ^ {16'h0, ck & 16'h0};
`endif
    endfunction

    // Words leave the DUT when tx_vld & tx_rdy at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && tx_vld && rdy) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_word: got %h with empty scoreboard", tx_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("stream_word", tx_data, e);
            end
        end
    end

    task automatic chk_zero(input string nm);
        chk({nm, "_tx_vld"},  {31'b0, tx_vld}, 32'd0);
        chk({nm, "_tx_data"}, tx_data, 32'd0);
        chk({nm, "_cnt"},     32'(cnt), 32'd0);
        chk({nm, "_busy"},    {31'b0, busy}, 32'd0);
        chk({nm, "_ovf"},     {31'b0, ovf}, 32'd0);
        chk({nm, "_ovf_cnt"}, {16'b0, ovf_cnt}, 32'd0);
    endtask

    // Reference: enabled channels taken in ascending order, cyclically; a data word
    // is stored only while fewer than D-2 words sit in the buffer (no reads when rnd=0).
    task automatic frame(input logic [CH-1:0] mk, input int nv, input bit rnd,
                         input bit fix_en, input logic [CH*DW-1:0] fix, input bit push);
        logic [CH-1:0] m;
        int            en[$];
        int            occ, ch;
        logic [15:0]   wc, ck, s;
        m = (mk == '0) ? 3'b001 : mk;
        for (int c = 0; c < CH; c++) if (m[c]) en.push_back(c);
        mask  = mk;
        start = 1'b1;
        rdy   = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        tick;
        rdy   = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        tick;
        if (push) exp_q.push_back({16'hA5A5, m_fcnt});
        m_fcnt++;
        occ = 1; wc = 0; ck = 0;
        for (int i = 0; i < nv; i++) begin
            if (rnd && $urandom_range(0, 3) == 0) begin
                vld = 1'b0;
                rdy = 1'($urandom_range(0, 1));
                tick;
            end
            data = fix_en ? fix : 48'({$urandom(), $urandom()});
            acc  = fix_en ? 1'b0 : 1'($urandom_range(0, 1));
            vld  = 1'b1;
            if (i == nv - 1) start = 1'b0;
            ch = en[i % en.size()];
            s  = data[ch*DW +: DW];
            if (rnd || occ < D - 2) begin
                if (push) exp_q.push_back(mdata(acc, ch, s));
                wc++;
                ck ^= s;
                occ++;
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            tick;
        end
        vld = 1'b0;
        if (nv == 0) begin
            start = 1'b0;
            tick;
        end
        if (push) exp_q.push_back(mtrl(wc, ck));
        tick;
        tick;
    endtask

    task automatic drain(input string nm);
        int cyc;
        cyc = 0;
        rdy = 1'b1;
        while (exp_q.size() != 0 && cyc < 300) begin
            tick;
            cyc++;
        end
        chk({nm, "_drained"}, 32'(exp_q.size()), 32'd0);
        tick;
        tick;
        chk({nm, "_empty"}, {31'b0, tx_vld}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick;

        exp_q.push_back(32'hA5A50000);
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(32'h05A61111);
            exp_q.push_back(32'h15A62222);
            exp_q.push_back(32'h25A63333);
        end
`ifdef LASER_PACK_CKSUM_EN
        exp_q.push_back(32'h00060000);
`else
        exp_q.push_back(32'h5A5A0006);
`endif
        frame(3'b111, 6, 1'b1, 1'b1, {16'h3333, 16'h2222, 16'h1111}, 1'b0);
        drain("basic");

        frame(3'b101, 4, 1'b1, 1'b0, '0, 1'b1);
        drain("mask101");
        frame(3'b000, 5, 1'b1, 1'b0, '0, 1'b1);
        drain("mask000");
        for (int k = 0; k < 6; k++) begin
            frame(3'($urandom_range(0, 7)), $urandom_range(1, 10), 1'b1, 1'b0, '0, 1'b1);
            drain("random");
        end
        frame(3'b011, 2, 1'b1, 1'b1, {16'h0000, 16'h0F0F, 16'h00FF}, 1'b1);
        drain("cksum");

        frame(3'b111, 20, 1'b0, 1'b0, '0, 1'b1);
        chk("ovf_fifo_cnt", 32'(cnt), 32'd15);
        chk("ovf_cnt", {16'b0, ovf_cnt}, 32'd7);
        chk("ovf_flag", {31'b0, ovf}, 32'd1);
        chk("ovf_idle", {31'b0, busy}, 32'd0);
        drain("ovf");

        mask  = 3'b111;
        start = 1'b1;
        rdy   = 1'b0;
        tick;
        tick;
        m_fcnt++;
        chk("ovf_cleared_on_rise", {31'b0, ovf}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            data = 48'({$urandom(), $urandom()});
            vld  = 1'b1;
            tick;
        end
        vld = 1'b0;
        clr = 1'b1;
        tick;
        clr = 1'b0;
        chk("clear_cnt", 32'(cnt), 32'd0);
        chk("clear_busy", {31'b0, busy}, 32'd0);
        exp_q.delete();
        start = 1'b0;
        rdy   = 1'b1;
        repeat (6) tick;
        chk("clear_no_trailer", {31'b0, tx_vld}, 32'd0);
        frame(3'b110, 3, 1'b1, 1'b0, '0, 1'b1);
        drain("after_clear");

        mask  = 3'b111;
        start = 1'b1;
        tick;
        tick;
        exp_q.push_back({16'hA5A5, m_fcnt});
        m_fcnt++;
        for (int i = 0; i < 4; i++) begin
            data = 48'({$urandom(), $urandom()});
            acc  = 1'($urandom_range(0, 1));
            vld  = 1'b1;
            exp_q.push_back(mdata(acc, i % 3, data[(i % 3)*DW +: DW]));
            rdy  = ~rdy;
            tick;
        end
        vld = 1'b0;
        rdy = ~rdy;
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        exp_q.delete();
        m_fcnt = 16'd0;
        start  = 1'b0;
        rdy    = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        frame(3'b111, 3, 1'b1, 1'b0, '0, 1'b1);
        drain("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
